seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the multi-digit board variant. A producer (the RISC-V core's output port or a test harness) writes a full frame of hex nibbles and decimal points through a valid/ready handshake. The block double-buffers the frame, scans the digits one at a time with a programmable dwell and anti-ghosting guard, and swaps in new data only at frame boundaries so the display never tears.

---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/seg7_decode.sv | 23 ++
 rtl/seg7_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph table, hex decoder and polarity helper.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = GLYPH_0;
      4'h1: s = GLYPH_1;
      4'h2: s = GLYPH_2;
      4'h3: s = GLYPH_3;
      4'h4: s = GLYPH_4;
      4'h5: s = GLYPH_5;
      4'h6: s = GLYPH_6;
      4'h7: s = GLYPH_7;
      4'h8: s = GLYPH_8;
      4'h9: s = GLYPH_9;
      4'hA: s = GLYPH_A;
      4'hB: s = GLYPH_B;
      4'hC: s = GLYPH_C;
      4'hD: s = GLYPH_D;
      4'hE: s = GLYPH_E;
      default: s = GLYPH_F;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_off_level(input logic active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble/dp decode with blanking and output polarity.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] nib,
  input  logic       dp_in,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp
);

  always_comb begin
    seg = blank ? GLYPH_BLANK : hex2seg(nib);
    dp  = dp_in & ~blank;
    if (ACTIVE_LOW) begin
      seg = ~seg;
      dp  = ~dp;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with double-buffered frames that
// swap only at frame boundaries (or immediately while the display is dark).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIG           = 4,
  parameter int PRESCALE       = 1000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              blank_lz,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic [NDIG-1:0]   wr_dp,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   dig_en,
  output logic              frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] I_LAST  = IW'(NDIG - 1);
  localparam logic [PW-1:0] GUARD_P = PW'(GUARD);
  localparam bit            AL      = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF = seg_off_level(AL);

  logic [PW-1:0]     p_q, p_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] disp_data_q, disp_data_d;
  logic [NDIG-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NDIG-1:0] pend_data_q, pend_data_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
  logic              pend_v_q, pend_v_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NDIG-1:0]   dig_en_q, dig_en_d;
  logic              frame_done_q, frame_done_d;

  logic              in_guard;
  logic              last_slot;
  logic              boundary;
  logic              lit;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic [NDIG-1:0]   lz_blank;
  logic              hi_zero;

  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (p_q < GUARD_P);
  end

  // Digit d>0 is a leading zero when it and every digit above it are 0 with no dp.
  always_comb begin
    hi_zero  = 1'b1;
    lz_blank = '0;
    for (int d = NDIG - 1; d >= 0; d--) begin
      hi_zero = hi_zero & (disp_data_q[4*d +: 4] == 4'h0) & ~disp_dp_q[d];
      if (d != 0) lz_blank[d] = blank_lz & hi_zero;
    end
  end

  assign last_slot = (p_q == P_LAST);
  assign boundary  = en & last_slot & (idx_q == I_LAST);
  assign cur_nib   = disp_data_q[4*idx_q +: 4];
  assign cur_dp    = disp_dp_q[idx_q];
  // Segments are driven only while the digit is enabled, so guard cycles are fully dark.
  assign lit       = en & ~in_guard & ~lz_blank[idx_q];

  seg7_decode #(.ACTIVE_LOW(AL)) u_decode (
    .nib   (cur_nib),
    .dp_in (cur_dp),
    .blank (~lit),
    .seg   (seg_d),
    .dp    (dp_d)
  );

  always_comb begin
    p_d          = p_q;
    idx_d        = idx_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_v_d     = pend_v_q;
    dig_en_d     = '0;
    frame_done_d = boundary;

    if (en) begin
      if (last_slot) begin
        p_d   = '0;
        idx_d = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        p_d = p_q + PW'(1);
      end
    end

    // While dark nothing can tear, so a pending frame is taken at once.
    if (pend_v_q && (boundary || !en)) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_v_d    = 1'b0;
    end else if (wr_valid && !pend_v_q) begin
      pend_data_d = wr_data;
      pend_dp_d   = wr_dp;
      pend_v_d    = 1'b1;
    end

    if (lit) dig_en_d[idx_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q          <= '0;
      idx_q        <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_v_q     <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= AL;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_v_q     <= pend_v_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = ~pend_v_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a cycle-count model predicts every output cycle of an
// active-high and an active-low instance driven with identical stimulus.
module tb_seg7_scan_driver;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = NDIG * PRESCALE;

  typedef struct packed {
    logic [6:0]      seg;
    logic            dp;
    logic [NDIG-1:0] dig_en;
    logic            fd;
    logic            rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, blank_lz, wr_valid;
  logic [4*NDIG-1:0] wr_data;
  logic [NDIG-1:0]   wr_dp;

  logic              rdy_h, dp_h, fd_h, rdy_l, dp_l, fd_l;
  logic [6:0]        seg_h, seg_l;
  logic [NDIG-1:0]   dig_en_h, dig_en_l;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NDIG(NDIG), .PRESCALE(PRESCALE), .GUARD(GUARD), .SEG_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz), .wr_valid(wr_valid),
    .wr_ready(rdy_h), .wr_data(wr_data), .wr_dp(wr_dp), .seg(seg_h), .dp(dp_h),
    .dig_en(dig_en_h), .frame_done(fd_h)
  );

  seg7_scan_driver #(.NDIG(NDIG), .PRESCALE(PRESCALE), .GUARD(GUARD), .SEG_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz), .wr_valid(wr_valid),
    .wr_ready(rdy_l), .wr_data(wr_data), .wr_dp(wr_dp), .seg(seg_l), .dp(dp_l),
    .dig_en(dig_en_l), .frame_done(fd_l)
  );

  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: one running cycle count within the frame plus two frame buffers.
  int                t_m;
  logic [4*NDIG-1:0] m_disp, m_pend;
  logic [NDIG-1:0]   m_ddp, m_pdp;
  logic              m_pv;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic cur_en, cur_blz;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_vec++;
        if ({seg_h, dp_h, dig_en_h, fd_h, rdy_h} !== mon_e) begin
          n_err++;
          $display("FAIL out_hi cyc=%0d got seg=%h dp=%b dig_en=%b fd=%b rdy=%b required seg=%h dp=%b dig_en=%b fd=%b rdy=%b",
                   cyc, seg_h, dp_h, dig_en_h, fd_h, rdy_h,
                   mon_e.seg, mon_e.dp, mon_e.dig_en, mon_e.fd, mon_e.rdy);
        end
        if ({~seg_l, ~dp_l, dig_en_l, fd_l, rdy_l} !== mon_e) begin
          n_err++;
          $display("FAIL out_lo cyc=%0d got seg=%h dp=%b dig_en=%b fd=%b rdy=%b required seg=%h dp=%b dig_en=%b fd=%b rdy=%b",
                   cyc, seg_l, dp_l, dig_en_l, fd_l, rdy_l,
                   ~mon_e.seg, ~mon_e.dp, mon_e.dig_en, mon_e.fd, mon_e.rdy);
        end
      end
    end
  end

  // Apply one cycle of inputs, predict the outputs after the coming edge, wait past it.
  task automatic step(input logic r, input logic e_in, input logic blz, input logic wv,
                      input logic [4*NDIG-1:0] wd, input logic [NDIG-1:0] wdp);
    int   ph, di;
    logic blanked, lit;
    exp_t e;
    rst = r; en = e_in; blank_lz = blz; wr_valid = wv; wr_data = wd; wr_dp = wdp;
    e = '0;
    if (!r) begin
      e.rdy = 1'b1;
      t_m = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
    end else begin
      ph = t_m % PRESCALE;
      di = t_m / PRESCALE;
      blanked = 1'b0;
      if (blz && di > 0) begin
        blanked = 1'b1;
        for (int j = di; j < NDIG; j++)
          if (m_disp[4*j +: 4] != 4'h0 || m_ddp[j]) blanked = 1'b0;
      end
      lit = e_in && (ph >= GUARD) && !blanked;
      if (lit) begin
        e.dig_en = NDIG'(1) << di;
        e.seg    = glyph_tbl[m_disp[4*di +: 4]];
        e.dp     = m_ddp[di];
      end
      e.fd = e_in && (t_m == FRAME - 1);
      if (m_pv && (!e_in || t_m == FRAME - 1)) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pv = 1'b0;
      end else if (wv && !m_pv) begin
        m_pend = wd; m_pdp = wdp; m_pv = 1'b1;
      end
      if (e_in) t_m = (t_m + 1) % FRAME;
      e.rdy = !m_pv;
    end
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, cur_en, cur_blz, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Hold the request until the producer-side view of the buffer says it is free.
  task automatic write_frame(input logic [4*NDIG-1:0] d, input logic [NDIG-1:0] dpv);
    int n = 0;
    while (m_pv && n < 200) begin
      step(1'b1, cur_en, cur_blz, 1'b1, d, dpv);
      n++;
    end
    if (m_pv) begin
      n_err++;
      $display("FAIL write_wait cyc=%0d got still_blocked required accepted", cyc);
    end else begin
      step(1'b1, cur_en, cur_blz, 1'b1, d, dpv);
    end
  endtask

  initial begin
    logic r, wv;
    logic [4*NDIG-1:0] wd;
    logic [NDIG-1:0]   wdp;
    int n;
    rst = 1'b0; en = 1'b0; blank_lz = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dp = '0;
    cur_en = 1'b1; cur_blz = 1'b0;
    @(negedge clk);
    #1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    write_frame(16'h1234, 4'h0);
    run(40);

    write_frame(16'hAAAA, 4'h0);
    write_frame(16'h5555, 4'h0);
    run(40);

    cur_blz = 1'b1;
    write_frame(16'h0070, 4'h0);
    run(40);
    write_frame(16'h0000, 4'h0);
    run(40);
    write_frame(16'h0000, 4'b0100);
    run(20);

    run(6);
    cur_en = 1'b0;
    write_frame(16'hBEEF, 4'b1010);
    run(5);
    cur_en = 1'b1;
    run(40);

    cur_blz = 1'b0;
    write_frame(16'h8888, 4'hF);
    run(20);

    write_frame(16'h1111, 4'h0);
    write_frame(16'h2222, 4'h3);
    run(5);
    repeat (3) step(1'b0, cur_en, cur_blz, 1'b0, '0, '0);
    run(40);

    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 399) != 0);
      cur_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) cur_blz = ~cur_blz;
      wv  = ($urandom_range(0, 2) == 0);
      wd  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      wdp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(r, cur_en, cur_blz, wv, wd, wdp);
    end

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain cyc=%0d got %0d pending required 0", cyc, sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
